// File: rtl/ir_pipeline_pkg.sv
// ir_pipeline_pkg: shared constants and stage names for the instruction-register pipeline.
package ir_pipeline_pkg;

    localparam int MAX_WIDTH  = 64;
    localparam int MAX_STAGES = 16;

    localparam logic [MAX_WIDTH-1:0] IR_BUBBLE = '0;

    typedef enum logic [3:0] {
        IF_ID  = 4'd0,
        ID_EX  = 4'd1,
        EX_MEM = 4'd2,
        MEM_WB = 4'd3,
        WB     = 4'd4
    } stage_idx_e;

endpackage

// File: rtl/ir_stage_reg.sv
// ir_stage_reg: one IR + valid register with clear/kill (zero), hold and load.
module ir_stage_reg
    import ir_pipeline_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             hold_i,
    input  logic             kill_i,
    input  logic [WIDTH-1:0] ir_i,
    input  logic             valid_i,
    output logic [WIDTH-1:0] ir_o,
    output logic             valid_o
);

    logic [WIDTH-1:0] ir_q;
    logic             valid_q;

    always_ff @(posedge clk) begin
        if (clear || kill_i) begin
            ir_q    <= IR_BUBBLE[WIDTH-1:0];
            valid_q <= 1'b0;
        end else if (!hold_i) begin
            ir_q    <= ir_i;
            valid_q <= valid_i;
        end
    end

    assign ir_o    = ir_q;
    assign valid_o = valid_q;

endmodule

// File: rtl/ir_pipeline.sv
// ir_pipeline: PC register plus STAGES-deep IR/valid chain with stall, flush and fetch bubbles.
// Optional saturating bubble counter on port bubble_count when IR_PIPELINE_BUBBLE_COUNT_EN is defined.
module ir_pipeline
    import ir_pipeline_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               STAGES   = 5,
    parameter int               PC_STEP  = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic                    clk,
    input  logic                    clear,
    output logic [WIDTH-1:0]        pc,
    input  logic [WIDTH-1:0]        fetch_inst,
    input  logic                    fetch_valid,
    input  logic                    stall,
    input  logic                    flush,
    input  logic [WIDTH-1:0]        redirect_pc,
    output logic [STAGES*WIDTH-1:0] stage_ir,
    output logic [STAGES-1:0]       stage_valid,
    output logic [WIDTH-1:0]        retire_ir,
    output logic                    retire_valid
`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
    ,
    output logic [31:0]             bubble_count
`endif
);

    logic [WIDTH-1:0]              pc_q, pc_d;
    logic [WIDTH-1:0]              fetch_ir;
    logic [STAGES-1:0][WIDTH-1:0]  ir_w, in_ir;
    logic [STAGES-1:0]             vld_w, in_vld;

    always_comb begin
        pc_d = clear ? RESET_PC :
               flush ? redirect_pc :
               stall ? pc_q :
               fetch_valid ? pc_q + WIDTH'(PC_STEP) : pc_q;
    end

    always_ff @(posedge clk) begin
        pc_q <= pc_d;
    end

    // Bubbles enter as zero so every invalid stage holds a zero IR.
    assign fetch_ir = fetch_valid ? fetch_inst : IR_BUBBLE[WIDTH-1:0];
    assign in_ir    = {ir_w[STAGES-2:0], fetch_ir};
    assign in_vld   = {vld_w[STAGES-2:0], fetch_valid};

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        ir_stage_reg #(.WIDTH(WIDTH)) u_reg (
            .clk     (clk),
            .clear   (clear),
            .hold_i  (stall),
            .kill_i  (flush),
            .ir_i    (in_ir[k]),
            .valid_i (in_vld[k]),
            .ir_o    (ir_w[k]),
            .valid_o (vld_w[k])
        );
    end

    assign pc           = pc_q;
    assign stage_ir     = ir_w;
    assign stage_valid  = vld_w;
    assign retire_ir    = ir_w[STAGES-1];
    assign retire_valid = vld_w[STAGES-1];

`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
    logic [31:0] bubble_q, bubble_d;
    logic        advance;

    assign advance = !clear && !flush && !stall;

    always_comb begin
        bubble_d = clear ? 32'd0 :
                   (advance && !fetch_valid && bubble_q != 32'hFFFF_FFFF) ? bubble_q + 32'd1 : bubble_q;
    end

    always_ff @(posedge clk) begin
        bubble_q <= bubble_d;
    end

    assign bubble_count = bubble_q;
`endif

endmodule

// File: tb/tb_ir_pipeline.sv
// tb_ir_pipeline: directed vector table plus hand sequences for PC wrap and a 2-stage 16-bit build.
module tb_ir_pipeline;

    logic        clk = 1'b0;
    logic        clear, fetch_valid, stall, flush;
    logic [31:0] fetch_inst, redirect_pc, pc, retire_ir;
    logic [159:0] stage_ir;
    logic [4:0]  stage_valid;
    logic        retire_valid;

    logic        clr2, fv2, zero1;
    logic [31:0] inst2, zero32, pc2, ret2;
    logic [159:0] sir2;
    logic [4:0]  sv2;
    logic        rv2;

    logic [15:0] zero16, pc3, ret3;
    logic [31:0] sir3;
    logic [1:0]  sv3;
    logic        rv3;

`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
    logic [31:0] bc, bc2, bc3;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    ir_pipeline dut (
        .clk(clk), .clear(clear), .pc(pc), .fetch_inst(fetch_inst), .fetch_valid(fetch_valid),
        .stall(stall), .flush(flush), .redirect_pc(redirect_pc), .stage_ir(stage_ir),
        .stage_valid(stage_valid), .retire_ir(retire_ir), .retire_valid(retire_valid)
`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
        , .bubble_count(bc)
`endif
    );

    ir_pipeline #(.RESET_PC(32'hFFFF_FFFC)) dut_wrap (
        .clk(clk), .clear(clr2), .pc(pc2), .fetch_inst(inst2), .fetch_valid(fv2),
        .stall(zero1), .flush(zero1), .redirect_pc(zero32), .stage_ir(sir2),
        .stage_valid(sv2), .retire_ir(ret2), .retire_valid(rv2)
`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
        , .bubble_count(bc2)
`endif
    );

    ir_pipeline #(.WIDTH(16), .STAGES(2)) dut_small (
        .clk(clk), .clear(clr2), .pc(pc3), .fetch_inst(inst2[15:0]), .fetch_valid(fv2),
        .stall(zero1), .flush(zero1), .redirect_pc(zero16), .stage_ir(sir3),
        .stage_valid(sv3), .retire_ir(ret3), .retire_valid(rv3)
`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
        , .bubble_count(bc3)
`endif
    );

    typedef struct {
        logic [3:0]  ctl;   // {clear, fetch_valid, stall, flush}
        logic [31:0] inst;
        logic [31:0] rpc;
        logic [31:0] pc;
        logic [4:0]  vld;
        logic [31:0] s0;
        logic [31:0] ret;
        logic [31:0] bc;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h", name, act, exp);
        end
    endtask

    initial begin
        tv.push_back('{4'b1000, 32'h0,    32'h0,   32'h0,   5'b00000, 32'h0,  32'h0, 32'd0});
        tv.push_back('{4'b0100, 32'h1,    32'h0,   32'h4,   5'b00001, 32'h1,  32'h0, 32'd0});
        tv.push_back('{4'b0100, 32'h2,    32'h0,   32'h8,   5'b00011, 32'h2,  32'h0, 32'd0});
        tv.push_back('{4'b0100, 32'h3,    32'h0,   32'hC,   5'b00111, 32'h3,  32'h0, 32'd0});
        tv.push_back('{4'b0100, 32'h4,    32'h0,   32'h10,  5'b01111, 32'h4,  32'h0, 32'd0});
        tv.push_back('{4'b0100, 32'h5,    32'h0,   32'h14,  5'b11111, 32'h5,  32'h1, 32'd0});
        tv.push_back('{4'b0110, 32'hDEAD, 32'h0,   32'h14,  5'b11111, 32'h5,  32'h1, 32'd0});
        tv.push_back('{4'b0110, 32'hDEAD, 32'h0,   32'h14,  5'b11111, 32'h5,  32'h1, 32'd0});
        tv.push_back('{4'b0110, 32'hDEAD, 32'h0,   32'h14,  5'b11111, 32'h5,  32'h1, 32'd0});
        tv.push_back('{4'b0100, 32'h6,    32'h0,   32'h18,  5'b11111, 32'h6,  32'h2, 32'd0});
        tv.push_back('{4'b0100, 32'h7,    32'h0,   32'h1C,  5'b11111, 32'h7,  32'h3, 32'd0});
        tv.push_back('{4'b0000, 32'h55,   32'h0,   32'h1C,  5'b11110, 32'h0,  32'h4, 32'd1});
        tv.push_back('{4'b0000, 32'h55,   32'h0,   32'h1C,  5'b11100, 32'h0,  32'h5, 32'd2});
        tv.push_back('{4'b0100, 32'h8,    32'h0,   32'h20,  5'b11001, 32'h8,  32'h6, 32'd2});
        tv.push_back('{4'b0100, 32'h9,    32'h0,   32'h24,  5'b10011, 32'h9,  32'h7, 32'd2});
        tv.push_back('{4'b0100, 32'hA,    32'h0,   32'h28,  5'b00111, 32'hA,  32'h0, 32'd2});
        tv.push_back('{4'b0100, 32'hB,    32'h0,   32'h2C,  5'b01111, 32'hB,  32'h0, 32'd2});
        tv.push_back('{4'b0100, 32'hC,    32'h0,   32'h30,  5'b11111, 32'hC,  32'h8, 32'd2});
        tv.push_back('{4'b0101, 32'hD,    32'h100, 32'h100, 5'b00000, 32'h0,  32'h0, 32'd2});
        tv.push_back('{4'b0100, 32'hE,    32'h0,   32'h104, 5'b00001, 32'hE,  32'h0, 32'd2});
        tv.push_back('{4'b0111, 32'hF,    32'h200, 32'h200, 5'b00000, 32'h0,  32'h0, 32'd2});
        tv.push_back('{4'b0100, 32'hF,    32'h0,   32'h204, 5'b00001, 32'hF,  32'h0, 32'd2});
        tv.push_back('{4'b1101, 32'h10,   32'h300, 32'h0,   5'b00000, 32'h0,  32'h0, 32'd0});
        tv.push_back('{4'b0010, 32'h11,   32'h0,   32'h0,   5'b00000, 32'h0,  32'h0, 32'd0});

        zero1 = 1'b0; zero16 = '0; zero32 = '0;
        clr2 = 1'b1; fv2 = 1'b0; inst2 = '0;

        foreach (tv[i]) begin
            {clear, fetch_valid, stall, flush} = tv[i].ctl;
            fetch_inst  = tv[i].inst;
            redirect_pc = tv[i].rpc;
            @(posedge clk);
            #1;
            chk($sformatf("v%0d pc", i), pc, tv[i].pc);
            chk($sformatf("v%0d valid", i), {27'd0, stage_valid}, {27'd0, tv[i].vld});
            chk($sformatf("v%0d s0", i), stage_ir[31:0], tv[i].s0);
            chk($sformatf("v%0d retire_ir", i), retire_ir, tv[i].ret);
            chk($sformatf("v%0d retire_valid", i), {31'd0, retire_valid}, {31'd0, tv[i].vld[4]});
            for (int k = 0; k < 5; k++)
                if (!stage_valid[k]) chk($sformatf("v%0d zero_ir%0d", i, k), stage_ir[k*32 +: 32], 32'h0);
`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
            chk($sformatf("v%0d bubbles", i), bc, tv[i].bc);
`endif
        end

        clear = 1'b0; fetch_valid = 1'b0; stall = 1'b0; flush = 1'b0;

        clr2 = 1'b1;
        @(posedge clk); #1;
        chk("wrap reset_pc", pc2, 32'hFFFF_FFFC);
        chk("small reset_pc", {16'd0, pc3}, 32'h0);
        chk("small reset valid", {30'd0, sv3}, 32'h0);

        clr2 = 1'b0; fv2 = 1'b1; inst2 = 32'h0000_1234;
        @(posedge clk); #1;
        chk("wrap pc", pc2, 32'h0);
        chk("wrap s0", sir2[31:0], 32'h1234);
        chk("small pc", {16'd0, pc3}, 32'h4);
        chk("small s0", sir3, 32'h0000_1234);
        chk("small valid1", {30'd0, sv3}, 32'h1);
        chk("small rv1", {31'd0, rv3}, 32'h0);

        fv2 = 1'b0;
        @(posedge clk); #1;
        chk("wrap pc hold", pc2, 32'h0);
        chk("small retire", {16'd0, ret3}, 32'h1234);
        chk("small rv2", {31'd0, rv3}, 32'h1);
        chk("small valid2", {30'd0, sv3}, 32'h2);

        @(posedge clk); #1;
        chk("small retire bubble", {16'd0, ret3}, 32'h0);
        chk("small rv3", {31'd0, rv3}, 32'h0);
`ifdef IR_PIPELINE_BUBBLE_COUNT_EN
        chk("small bubbles", bc3, 32'd2);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
